serial_adder: RTL

- Parametrised multi-cycle adder, successor to the single-bit dataflow half adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using shift registers and a registered carry.
- Gives sum, carry-out and signed overflow.
- Sits between operand producers and result consumers behind valid/ready handshakes on both sides, so datapaths can trade area for latency.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_digit.sv | 26 ++
 rtl/serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder.
// Operand width and digit size are checked here so every user sees the same rules.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic bit params_ok(input int unsigned width, input int unsigned digit);
      return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

   // Number of clock edges spent in BUSY per operation.
   function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
      return (digit == 0) ? 1 : width / digit;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder built from per-bit sum/carry equations.
// The top level feeds it one digit of each operand per clock.
module serial_adder_digit
   import serial_adder_pkg::*;
#(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] cc;

   assign cc[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : gen_bit
      assign s[i]     = x[i] ^ y[i] ^ cc[i];
      assign cc[i+1]  = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
   end

   assign co = cc[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: a + b + cin computed DIGIT bits per clock, LSB first,
// behind valid/ready handshakes on both the operand and result sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N    = num_digits(WIDTH, DIGIT);
   localparam int unsigned CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!params_ok(WIDTH, DIGIT)) begin : gen_param_check
      $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   state_t           state;
   logic [WIDTH-1:0] sha;
   logic [WIDTH-1:0] shb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sign_a;
   logic             sign_b;

   logic [DIGIT-1:0] d;
   logic             c;
   logic [WIDTH-1:0] sum_next;
   logic             ovf_next;

   serial_adder_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .x (sha[DIGIT-1:0]),
      .y (shb[DIGIT-1:0]),
      .ci(carry),
      .s (d),
      .co(c)
   );

   // New digit enters at the top; after N steps the LSB digit has reached bit 0.
   assign sum_next = WIDTH'({d, sum} >> DIGIT);
   assign ovf_next = (sign_a == sign_b) && (sum_next[WIDTH-1] != sign_a);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sha       <= '0;
         shb       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sha      <= a;
                  shb      <= b;
                  carry    <= cin;
                  sign_a   <= a[WIDTH-1];
                  sign_b   <= b[WIDTH-1];
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               carry <= c;
               sha   <= sha >> DIGIT;
               shb   <= shb >> DIGIT;
               sum   <= sum_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout      <= c;
                  ovf       <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Re-accept only from IDLE, so a handshake edge never also takes operands.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
